// File: rtl/stream_minmax_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_minmax_pkg
// Description : Shared ALU constants for the streaming min/max reduction unit:
//               FSM state encoding and reduction-mode encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_minmax_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Reduction mode, sampled with the first element of a sequence
  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

endpackage
`default_nettype wire

// File: rtl/stream_minmax_comp.sv
`default_nettype none
// ============================================================================
// Module      : comp
// Description : Unsigned less-than primitive: out = (a < b).
// Revision    : 1.0 - initial release
// ============================================================================
module comp #(
  parameter int LEN = 8
) (
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] b,
  output logic           out
);

  // Pure combinational unsigned compare
  assign out = (a < b);

endmodule
`default_nettype wire

// File: rtl/stream_minmax.sv
`default_nettype none
// ============================================================================
// Module      : stream_minmax
// Description : Streaming min/max reduction. Tracks the running extreme value
//               and its 0-based position over a valid/ready operand stream and
//               emits the result after the element flagged in_last.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_minmax
  import stream_minmax_pkg::*;
#(
  parameter int LEN   = 8,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LEN-1:0]   in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LEN-1:0]   out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_ovf
);

  logic [1:0]       r_state;
  logic [LEN-1:0]   r_best;
  logic [IDX_W-1:0] r_best_idx;
  logic [IDX_W-1:0] r_cnt;
  logic             r_mode;
  logic             r_ovf;

  logic             w_fire_in;
  logic             w_fire_out;
  logic             w_replace;
  logic [LEN-1:0]   w_cmp_a;
  logic [LEN-1:0]   w_cmp_b;
  logic [IDX_W-1:0] w_cnt_next;

  // Handshake decode from registered state; in_ready is also masked while
  // reset is asserted so no operand is accepted in a reset cycle.
  always_comb begin
    in_ready   = ((r_state == IDLE) || (r_state == ACCUM)) && !reset;
    out_valid  = (r_state == DONE);
    w_fire_in  = in_valid && in_ready;
    w_fire_out = out_valid && out_ready;
    w_cnt_next = r_cnt + IDX_W'(1);
  end

  // Operand steering: max asks "best < new", min asks "new < best", so a
  // single strict less-than gives the replace enable and ties never replace.
  always_comb begin
    w_cmp_a = r_best;
    w_cmp_b = in_data;
    if (r_mode == MODE_MIN) begin
      w_cmp_a = in_data;
      w_cmp_b = r_best;
    end
  end

  comp #(
    .LEN (LEN)
  ) u_comp (
    .a   (w_cmp_a),
    .b   (w_cmp_b),
    .out (w_replace)
  );

  // Result registers feed the outputs directly; they are untouched in DONE,
  // so the result is stable for as long as the consumer stalls.
  assign out_data = r_best;
  assign out_idx  = r_best_idx;
  assign out_ovf  = r_ovf;

  // Sequence FSM and running-extreme tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_best     <= '0;
      r_best_idx <= '0;
      r_cnt      <= '0;
      r_mode     <= MODE_MAX;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fire_in) begin
            r_best     <= in_data;
            r_best_idx <= '0;
            r_cnt      <= IDX_W'(1);
            r_mode     <= mode;
            r_ovf      <= 1'b0;
            r_state    <= in_last ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (w_fire_in) begin
            if (w_replace) begin
              r_best     <= in_data;
              r_best_idx <= r_cnt;
            end
            r_cnt <= w_cnt_next;
            if (w_cnt_next == '0) begin
              r_ovf <= 1'b1;
            end
            if (in_last) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          if (w_fire_out) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_minmax.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_minmax
// Description : Directed self-checking bench for stream_minmax. A second
//               instance with IDX_W=2 shares the input stream to exercise
//               position-counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_minmax;

  localparam int LEN = 8;

  logic           clk;
  logic           reset;
  logic           mode;
  logic           in_valid;
  logic [LEN-1:0] in_data;
  logic           in_last;
  logic           out_ready;

  logic           in_ready;
  logic           out_valid;
  logic [LEN-1:0] out_data;
  logic [7:0]     out_idx;
  logic           out_ovf;

  logic           w_in_ready2;
  logic           w_out_valid2;
  logic [LEN-1:0] w_out_data2;
  logic [1:0]     w_out_idx2;
  logic           w_out_ovf2;

  int n_checks = 0;
  int n_fail   = 0;

  stream_minmax #(.LEN(LEN), .IDX_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_ovf   (out_ovf)
  );

  stream_minmax #(.LEN(LEN), .IDX_W(2)) dut_small (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (w_in_ready2),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (w_out_valid2),
    .out_ready (out_ready),
    .out_data  (w_out_data2),
    .out_idx   (w_out_idx2),
    .out_ovf   (w_out_ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send_beat(input logic [LEN-1:0] d, input logic last, input logic m);
    int waited;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    mode     = m;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL send_beat_timeout: in_ready=%0b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take_output();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %0b required 0", in_ready);
    end
    n_checks++;
    if ({out_valid, out_data, out_idx, out_ovf} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%0b data=%0h idx=%0h ovf=%0b required all 0",
               out_valid, out_data, out_idx, out_ovf);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_in_ready: got %0b required 1", in_ready);
    end
  endtask

  task automatic test_max_seq();
    send_beat(8'd3, 1'b0, 1'b0);
    send_beat(8'd9, 1'b0, 1'b0);
    send_beat(8'd9, 1'b0, 1'b0);
    send_beat(8'd2, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL max_latency: valid=%0b ready=%0b required 1/0", out_valid, in_ready);
    end
    n_checks++;
    if (out_data !== 8'd9 || out_idx !== 8'd1 || out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL max_result: data=%0d idx=%0d ovf=%0b required 9/1/0", out_data, out_idx, out_ovf);
    end
    take_output();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL max_drain: valid=%0b ready=%0b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_min_single();
    send_beat(8'h7F, 1'b1, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h7F || out_idx !== 8'd0) begin
      n_fail++; $display("FAIL min_single: valid=%0b data=%0h idx=%0d required 1/7f/0", out_valid, out_data, out_idx);
    end
    take_output();
  endtask

  task automatic test_backpressure();
    send_beat(8'd5, 1'b0, 1'b0);
    send_beat(8'd200, 1'b0, 1'b0);
    send_beat(8'd17, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 8'd200 || out_idx !== 8'd1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%0b ready=%0b data=%0d idx=%0d required 1/0/200/1",
                 i, out_valid, in_ready, out_data, out_idx);
      end
      tick();
    end
    take_output();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: ready=%0b valid=%0b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_mode_stall();
    send_beat(8'd40, 1'b0, 1'b1);
    mode = 1'b0;
    tick();
    tick();
    send_beat(8'd10, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_hold: valid=%0b ready=%0b required 0/1", out_valid, in_ready);
    end
    send_beat(8'd55, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd10 || out_idx !== 8'd1) begin
      n_fail++; $display("FAIL mode_sample: valid=%0b data=%0d idx=%0d required 1/10/1", out_valid, out_data, out_idx);
    end
    take_output();
  endtask

  task automatic test_overflow();
    send_beat(8'd1, 1'b0, 1'b0);
    send_beat(8'd2, 1'b0, 1'b0);
    send_beat(8'd3, 1'b0, 1'b0);
    send_beat(8'd4, 1'b0, 1'b0);
    send_beat(8'd0, 1'b0, 1'b0);
    send_beat(8'd9, 1'b1, 1'b0);
    n_checks++;
    if (w_out_valid2 !== 1'b1 || w_out_data2 !== 8'd9 || w_out_idx2 !== 2'd1 || w_out_ovf2 !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_small: valid=%0b data=%0d idx=%0d ovf=%0b required 1/9/1/1",
               w_out_valid2, w_out_data2, w_out_idx2, w_out_ovf2);
    end
    n_checks++;
    if (out_data !== 8'd9 || out_idx !== 8'd5 || out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_wide: data=%0d idx=%0d ovf=%0b required 9/5/0", out_data, out_idx, out_ovf);
    end
    take_output();
  endtask

  task automatic test_reset_mid();
    send_beat(8'd4, 1'b0, 1'b0);
    send_beat(8'd5, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_ready: got %0b required 0", in_ready);
    end
    tick();
    n_checks++;
    if ({out_valid, out_data, out_idx, out_ovf} !== 18'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: valid=%0b data=%0h idx=%0h ovf=%0b required all 0",
               out_valid, out_data, out_idx, out_ovf);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_no_output[%0d]: valid=%0b required 0", i, out_valid);
      end
    end
    send_beat(8'd4, 1'b0, 1'b0);
    send_beat(8'd8, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd8 || out_idx !== 8'd1) begin
      n_fail++; $display("FAIL rst_mid_after: valid=%0b data=%0d idx=%0d required 1/8/1", out_valid, out_data, out_idx);
    end
    take_output();
  endtask

  initial begin
    reset     = 1'b1;
    mode      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_max_seq();
    test_min_single();
    test_backpressure();
    test_mode_stall();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
